// File: rtl/lenet_axil_regif.sv
// ============================================================================
//  Module   : lenet_axil_regif
//  Brief    : AXI4-Lite register front end of the LeNet accelerator. Turns
//             host writes into weight/bias/feature-map word streams, issues
//             the core start pulse and reports done/result back to the host.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lenet_axil_regif #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int N_WEIGHT           = 3220,
    parameter int N_BIAS             = 10,
    parameter int N_FMAP             = 784
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   wgt_data,
    output logic                            wgt_valid,
    input  logic                            wgt_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   bias_data,
    output logic                            bias_valid,
    input  logic                            bias_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   fmap_data,
    output logic                            fmap_valid,
    input  logic                            fmap_ready,
    output logic                            core_clr,
    output logic                            core_start,
    input  logic                            core_done,
    input  logic [3:0]                      core_result
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_PUSH = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    localparam logic [2:0]  c_A_CTRL   = 3'd0;
    localparam logic [2:0]  c_A_WGT    = 3'd1;
    localparam logic [2:0]  c_A_BIAS   = 3'd2;
    localparam logic [2:0]  c_A_FMAP   = 3'd3;
    localparam logic [2:0]  c_A_LDCNT  = 3'd4;
    localparam logic [2:0]  c_A_DONE   = 3'd5;
    localparam logic [2:0]  c_A_RESULT = 3'd6;
    localparam logic [2:0]  c_A_SOFT   = 3'd7;
    localparam logic [11:0] c_WGT_MAX  = 12'(N_WEIGHT);
    localparam logic [3:0]  c_BIAS_MAX = 4'(N_BIAS);
    localparam logic [9:0]  c_FMAP_MAX = 10'(N_FMAP);
    localparam logic [1:0]  c_OKAY     = 2'b00;
    localparam logic [1:0]  c_SLVERR   = 2'b10;

    wstate_t                         r_wstate;
    rstate_t                         r_rstate;
    logic [2:0]                      r_widx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_push_data;
    logic                            r_wgt_valid, r_bias_valid, r_fmap_valid;
    logic                            r_bvalid;
    logic [1:0]                      r_bresp;
    logic                            r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic                            r_run, r_soft;
    logic [11:0]                     r_wgt_cnt;
    logic [3:0]                      r_bias_cnt;
    logic [9:0]                      r_fmap_cnt;
    logic                            r_started, r_done, r_core_start;
    logic [3:0]                      r_result;

    logic                            w_wr_hs, w_is_stream, w_stream_ok, w_push_ready;
    logic                            w_run_fall, w_full;
    logic [2:0]                      w_widx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_data;
    logic                            w_unused;

    assign w_unused = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_awprot,
                        s_axi_arprot, s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

    // Address and data are accepted together, only while the write side is idle.
    assign w_wr_hs       = (r_wstate == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign w_widx        = s_axi_awaddr[4:2];
    assign s_axi_awready = w_wr_hs;
    assign s_axi_wready  = w_wr_hs;
    assign s_axi_arready = (r_rstate == R_IDLE) && s_axi_arvalid;
    assign w_run_fall    = w_wr_hs && (w_widx == c_A_CTRL) && s_axi_wstrb[0]
                           && r_run && !s_axi_wdata[0];
    assign w_full        = (r_wgt_cnt == c_WGT_MAX) && (r_bias_cnt == c_BIAS_MAX)
                           && (r_fmap_cnt == c_FMAP_MAX);

    always_comb begin
        w_is_stream = 1'b0;
        w_stream_ok = 1'b0;
        case (w_widx)
            c_A_WGT:  begin w_is_stream = 1'b1; w_stream_ok = r_run && (r_wgt_cnt  < c_WGT_MAX);  end
            c_A_BIAS: begin w_is_stream = 1'b1; w_stream_ok = r_run && (r_bias_cnt < c_BIAS_MAX); end
            c_A_FMAP: begin w_is_stream = 1'b1; w_stream_ok = r_run && (r_fmap_cnt < c_FMAP_MAX); end
            default:  ;
        endcase
    end

    always_comb begin
        case (r_widx)
            c_A_WGT:  w_push_ready = wgt_ready;
            c_A_BIAS: w_push_ready = bias_ready;
            c_A_FMAP: w_push_ready = fmap_ready;
            default:  w_push_ready = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate     <= W_IDLE;
            r_widx       <= 3'd0;
            r_push_data  <= '0;
            r_wgt_valid  <= 1'b0;
            r_bias_valid <= 1'b0;
            r_fmap_valid <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= c_OKAY;
            r_run        <= 1'b0;
            r_soft       <= 1'b0;
            r_wgt_cnt    <= 12'd0;
            r_bias_cnt   <= 4'd0;
            r_fmap_cnt   <= 10'd0;
            r_started    <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= 4'd0;
            r_core_start <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_hs) begin
                        r_widx <= w_widx;
                        if (w_is_stream && w_stream_ok) begin
                            r_push_data  <= s_axi_wdata;
                            r_wgt_valid  <= (w_widx == c_A_WGT);
                            r_bias_valid <= (w_widx == c_A_BIAS);
                            r_fmap_valid <= (w_widx == c_A_FMAP);
                            r_wstate     <= W_PUSH;
                        end else begin
                            if (w_widx == c_A_CTRL && s_axi_wstrb[0]) r_run  <= s_axi_wdata[0];
                            if (w_widx == c_A_SOFT && s_axi_wstrb[0]) r_soft <= s_axi_wdata[0];
                            r_bresp  <= w_is_stream ? c_SLVERR : c_OKAY;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_PUSH: begin
                    if (w_push_ready) begin
                        r_wgt_valid  <= 1'b0;
                        r_bias_valid <= 1'b0;
                        r_fmap_valid <= 1'b0;
                        if (r_widx == c_A_WGT  && r_wgt_cnt  != c_WGT_MAX)  r_wgt_cnt  <= r_wgt_cnt  + 12'd1;
                        if (r_widx == c_A_BIAS && r_bias_cnt != c_BIAS_MAX) r_bias_cnt <= r_bias_cnt + 4'd1;
                        if (r_widx == c_A_FMAP && r_fmap_cnt != c_FMAP_MAX) r_fmap_cnt <= r_fmap_cnt + 10'd1;
                        r_bresp  <= c_OKAY;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase

            if (r_run && !r_started && w_full && !r_soft && !w_run_fall) begin
                r_core_start <= 1'b1;
                r_started    <= 1'b1;
            end
            if (core_done && r_started) begin
                r_done   <= 1'b1;
                r_result <= core_result;
            end
            // Dropping run keeps weights/bias loaded so only a new image is needed.
            if (w_run_fall) begin
                r_done     <= 1'b0;
                r_started  <= 1'b0;
                r_fmap_cnt <= 10'd0;
            end
            if (r_soft) begin
                r_wgt_cnt  <= 12'd0;
                r_bias_cnt <= 4'd0;
                r_fmap_cnt <= 10'd0;
                r_started  <= 1'b0;
                r_done     <= 1'b0;
                r_result   <= 4'd0;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (s_axi_araddr[4:2])
            c_A_CTRL:   w_rd_data[0]    = r_run;
            c_A_LDCNT:  w_rd_data[25:0] = {r_fmap_cnt, r_bias_cnt, r_wgt_cnt};
            c_A_DONE:   w_rd_data[0]    = r_done;
            c_A_RESULT: w_rd_data[3:0]  = r_result;
            c_A_SOFT:   w_rd_data[0]    = r_soft;
            default:    ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        r_rdata  <= w_rd_data;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_bresp  = r_bresp;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = c_OKAY;
    assign s_axi_rvalid = r_rvalid;
    assign wgt_data     = r_push_data;
    assign bias_data    = r_push_data;
    assign fmap_data    = r_push_data;
    assign wgt_valid    = r_wgt_valid;
    assign bias_valid   = r_bias_valid;
    assign fmap_valid   = r_fmap_valid;
    assign core_clr     = r_soft;
    assign core_start   = r_core_start;

endmodule

`default_nettype wire

// File: tb/tb_lenet_axil_regif.sv
// ============================================================================
//  Module   : tb_lenet_axil_regif
//  Brief    : Scoreboard bench for lenet_axil_regif with a register-level
//             reference model and randomized data, strobes and backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lenet_axil_regif;

    localparam int N_WEIGHT = 3220;
    localparam int N_BIAS   = 10;
    localparam int N_FMAP   = 784;

    logic        ACLK, ARESETN;
    logic [4:0]  s_axi_awaddr, s_axi_araddr;
    logic [2:0]  s_axi_awprot, s_axi_arprot;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] wgt_data, bias_data, fmap_data;
    logic        wgt_valid, wgt_ready, bias_valid, bias_ready, fmap_valid, fmap_ready;
    logic        core_clr, core_start, core_done;
    logic [3:0]  core_result;

    lenet_axil_regif #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
        .N_WEIGHT(N_WEIGHT), .N_BIAS(N_BIAS), .N_FMAP(N_FMAP)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wgt_data(wgt_data), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .bias_data(bias_data), .bias_valid(bias_valid), .bias_ready(bias_ready),
        .fmap_data(fmap_data), .fmap_valid(fmap_valid), .fmap_ready(fmap_ready),
        .core_clr(core_clr), .core_start(core_start),
        .core_done(core_done), .core_result(core_result)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int checks = 0;
    int errors = 0;
    int starts_seen = 0;
    bit stall_wgt = 1'b0;
    bit abort_wr  = 1'b0;

    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];
    logic [31:0] exp_wgt[$], exp_bias[$], exp_fmap[$];

    // Reference model: register contents as the host would reason about them.
    bit m_run, m_soft, m_done, m_started;
    int m_wgt, m_bias, m_fmap, m_result, m_starts_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pop_check(input string name, inout logic [31:0] q[$], input logic [31:0] act);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected transfer 0x%08h, none required at %0t", name, act, $time);
        end else begin
            check(name, act, q.pop_front());
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_soft = 0; m_done = 0; m_started = 0;
        m_wgt = 0; m_bias = 0; m_fmap = 0; m_result = 0;
    endfunction

    function automatic void model_write(input logic [4:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [1:0] resp = 2'b00;
        case (int'(addr[4:2]))
            0: if (strb[0]) begin
                   if (m_run && !data[0]) begin m_done = 0; m_started = 0; m_fmap = 0; end
                   m_run = data[0];
               end
            1: if (!m_run || m_wgt >= N_WEIGHT) resp = 2'b10;
               else begin exp_wgt.push_back(data); m_wgt++; end
            2: if (!m_run || m_bias >= N_BIAS) resp = 2'b10;
               else begin exp_bias.push_back(data); m_bias++; end
            3: if (!m_run || m_fmap >= N_FMAP) resp = 2'b10;
               else begin exp_fmap.push_back(data); m_fmap++; end
            7: if (strb[0]) m_soft = data[0];
            default: ;
        endcase
        if (m_soft) begin
            m_wgt = 0; m_bias = 0; m_fmap = 0; m_started = 0; m_done = 0; m_result = 0;
        end
        if (m_run && !m_started && !m_soft && m_wgt == N_WEIGHT && m_bias == N_BIAS
            && m_fmap == N_FMAP) begin
            m_started = 1;
            m_starts_exp++;
        end
        exp_b.push_back(resp);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        case (int'(addr[4:2]))
            0: return {31'd0, m_run};
            4: return (m_fmap << 16) | (m_bias << 12) | m_wgt;
            5: return {31'd0, m_done};
            6: return 32'(m_result);
            7: return {31'd0, m_soft};
            default: return 32'd0;
        endcase
    endfunction

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        bit hs = 0;
        model_write(addr, data, strb);
        @(posedge ACLK); #1;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awprot = 3'($urandom); s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        while (!hs && !abort_wr) begin
            @(negedge ACLK); hs = s_axi_awready && s_axi_wready;
            @(posedge ACLK); #1;
            if (++n > 1000) begin check("aw_timeout", 0, 1); break; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        hs = 0; n = 0;
        while (!hs && !abort_wr) begin
            s_axi_bready = ($urandom_range(0, 2) != 0);
            @(negedge ACLK); hs = s_axi_bvalid && s_axi_bready;
            @(posedge ACLK); #1;
            if (++n > 2000) begin check("b_timeout", 0, 1); break; end
        end
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr);
        int n = 0;
        bit hs = 0;
        exp_r.push_back(model_read(addr));
        @(posedge ACLK); #1;
        s_axi_araddr = addr; s_axi_arprot = 3'($urandom); s_axi_arvalid = 1'b1;
        while (!hs) begin
            @(negedge ACLK); hs = s_axi_arready;
            @(posedge ACLK); #1;
            if (++n > 1000) begin check("ar_timeout", 0, 1); break; end
        end
        s_axi_arvalid = 1'b0;
        hs = 0; n = 0;
        while (!hs) begin
            s_axi_rready = ($urandom_range(0, 2) != 0);
            @(negedge ACLK); hs = s_axi_rvalid && s_axi_rready;
            @(posedge ACLK); #1;
            if (++n > 1000) begin check("r_timeout", 0, 1); break; end
        end
        s_axi_rready = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] res);
        @(posedge ACLK); #1;
        core_done = 1'b1; core_result = res;
        if (m_started && !m_soft) begin m_done = 1; m_result = int'(res); end
        @(posedge ACLK); #1;
        core_done = 1'b0;
    endtask

    task automatic stall_write(input logic [31:0] d);
        stall_wgt = 1'b1;
        @(posedge ACLK); #1;
        fork
            axi_write(5'h04, d, 4'hF);
            begin
                int n = 0;
                bit bad = 0;
                logic [31:0] d0;
                while (!wgt_valid && n < 100) begin @(negedge ACLK); n++; end
                check("stall_valid_up", {31'd0, wgt_valid}, 1);
                d0 = wgt_data;
                fork
                    for (int k = 0; k < 20; k++) begin
                        @(negedge ACLK);
                        if (s_axi_bvalid || !wgt_valid || wgt_data !== d0) bad = 1;
                    end
                    axi_read(5'h14);
                join
                check("stall_hold", {31'd0, bad}, 0);
                check("stall_data", d0, d);
                stall_wgt = 1'b0;
            end
        join
    endtask

    // Stream backpressure: random unless a stall is being forced on weights.
    initial begin
        wgt_ready = 1'b0; bias_ready = 1'b0; fmap_ready = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            wgt_ready  = !stall_wgt && ($urandom_range(0, 3) != 0);
            bias_ready = ($urandom_range(0, 3) != 0);
            fmap_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (s_axi_bvalid && s_axi_bready) begin
                    if (exp_b.size() == 0) check("bresp_unexpected", 1, 0);
                    else check("bresp", {30'd0, s_axi_bresp}, {30'd0, exp_b.pop_front()});
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    pop_check("rdata", exp_r, s_axi_rdata);
                    check("rresp", {30'd0, s_axi_rresp}, 0);
                end
                if (wgt_valid && wgt_ready)   pop_check("wgt_data", exp_wgt, wgt_data);
                if (bias_valid && bias_ready) pop_check("bias_data", exp_bias, bias_data);
                if (fmap_valid && fmap_ready) pop_check("fmap_data", exp_fmap, fmap_data);
                if (core_start) starts_seen++;
            end
        end
    end

    initial begin
        model_reset();
        m_starts_exp = 0;
        ARESETN = 1'b0; core_done = 1'b0; core_result = 4'd0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (5) @(posedge ACLK);
        #1;
        check("reset_ctrl_outputs", {20'd0, s_axi_awready, s_axi_wready, s_axi_bvalid,
              s_axi_arready, s_axi_rvalid, wgt_valid, bias_valid, fmap_valid, core_clr,
              core_start, s_axi_bresp | s_axi_rresp}, 0);
        check("reset_data_outputs", s_axi_rdata | wgt_data | bias_data | fmap_data, 0);
        ARESETN = 1'b1;

        for (int a = 0; a < 8; a++) axi_read(5'(a * 4));

        pulse_done(4'd3);
        axi_read(5'h14);
        axi_write(5'h0C, 32'h5, 4'hF);
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h00, 32'h0, 4'b1110);
        axi_read(5'h00);

        for (int i = 0; i < N_WEIGHT; i++) begin
            if (i == 100) stall_write($urandom);
            else axi_write(5'h04, $urandom, 4'($urandom));
        end
        for (int i = 0; i < N_BIAS; i++) axi_write(5'h08, $urandom, 4'($urandom));
        axi_read(5'h10);
        check("no_early_start", 32'(starts_seen), 0);
        for (int i = 0; i < N_FMAP; i++) axi_write(5'h0C, $urandom, 4'($urandom));
        repeat (5) @(posedge ACLK);
        check("start_count_first", 32'(starts_seen), 32'(m_starts_exp));
        axi_read(5'h10);

        axi_write(5'h04, $urandom, 4'hF);
        axi_write(5'h08, $urandom, 4'hF);
        axi_write(5'h0C, $urandom, 4'hF);
        axi_read(5'h10);

        pulse_done(4'd7);
        axi_read(5'h14);
        axi_read(5'h18);
        axi_write(5'h00, 32'h0, 4'hF);
        axi_read(5'h14);
        axi_read(5'h10);
        axi_write(5'h0C, 32'h5, 4'hF);

        axi_write(5'h00, 32'h1, 4'hF);
        for (int i = 0; i < N_FMAP; i++) axi_write(5'h0C, $urandom, 4'($urandom));
        repeat (5) @(posedge ACLK);
        check("start_count_second", 32'(starts_seen), 32'(m_starts_exp));

        axi_write(5'h1C, 32'h0, 4'hF);
        axi_write(5'h1C, 32'h1, 4'hF);
        check("core_clr_set", {31'd0, core_clr}, 1);
        axi_read(5'h10);
        axi_read(5'h14);
        axi_read(5'h1C);
        axi_write(5'h1C, 32'h0, 4'hF);
        check("core_clr_release", {31'd0, core_clr}, 0);

        axi_write(5'h04, 32'h1234_5678, 4'hF);
        stall_wgt = 1'b1;
        @(posedge ACLK); #1;
        fork
            axi_write(5'h04, 32'hDEAD_BEEF, 4'hF);
            begin
                int n = 0;
                while (!wgt_valid && n < 100) begin @(negedge ACLK); n++; end
                check("push_before_reset", {31'd0, wgt_valid}, 1);
                #2 ARESETN = 1'b0;
                #1 check("valid_drop_async", {31'd0, wgt_valid}, 0);
                abort_wr = 1'b1;
                exp_b.delete();
                exp_wgt.delete();
                model_reset();
                @(posedge ACLK); @(posedge ACLK); #1;
                ARESETN = 1'b1;
            end
        join
        abort_wr = 1'b0;
        stall_wgt = 1'b0;
        axi_read(5'h10);
        axi_read(5'h00);
        check("core_clr_after_reset", {31'd0, core_clr}, 0);

        repeat (10) @(posedge ACLK);
        check("scoreboard_drained", 32'(exp_b.size() + exp_r.size() + exp_wgt.size()
              + exp_bias.size() + exp_fmap.size()), 0);
        check("start_count_final", 32'(starts_seen), 32'(m_starts_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
